// File: rtl/serdesphy_ana_rx_deser_if.sv
// Line-side inputs and recovered-data/status outputs of the RX deserializer mock.
// Optional PRBS checker signals appear when SERDESPHY_RX_PRBS_CHK_EN is defined.
interface serdesphy_ana_rx_deser_if;
  logic       deserializer_enable;
  logic       deserializer_reset_n;
  logic       deserializer_bypass;
  logic       lpbk_en;
  logic       rxp;
  logic       rxn;
  logic       lpbk_txp;
  logic       lpbk_txn;
  logic       deserializer_data;
  logic [9:0] word_out;
  logic       word_valid;
  logic       deserializer_ready;
  logic       deserializer_lock;
  logic       deserializer_error;
  logic       deserializer_active;
  logic       deserializer_status;
`ifdef SERDESPHY_RX_PRBS_CHK_EN
  logic        prbs_chk_en;
  logic        prbs_clr;
  logic [15:0] prbs_err_cnt;

  modport master (
    output deserializer_enable, deserializer_reset_n, deserializer_bypass, lpbk_en,
           rxp, rxn, lpbk_txp, lpbk_txn, prbs_chk_en, prbs_clr,
    input  deserializer_data, word_out, word_valid, deserializer_ready,
           deserializer_lock, deserializer_error, deserializer_active,
           deserializer_status, prbs_err_cnt
  );

  modport slave (
    input  deserializer_enable, deserializer_reset_n, deserializer_bypass, lpbk_en,
           rxp, rxn, lpbk_txp, lpbk_txn, prbs_chk_en, prbs_clr,
    output deserializer_data, word_out, word_valid, deserializer_ready,
           deserializer_lock, deserializer_error, deserializer_active,
           deserializer_status, prbs_err_cnt
  );
`else
  modport master (
    output deserializer_enable, deserializer_reset_n, deserializer_bypass, lpbk_en,
           rxp, rxn, lpbk_txp, lpbk_txn,
    input  deserializer_data, word_out, word_valid, deserializer_ready,
           deserializer_lock, deserializer_error, deserializer_active,
           deserializer_status
  );

  modport slave (
    input  deserializer_enable, deserializer_reset_n, deserializer_bypass, lpbk_en,
           rxp, rxn, lpbk_txp, lpbk_txn,
    output deserializer_data, word_out, word_valid, deserializer_ready,
           deserializer_lock, deserializer_error, deserializer_active,
           deserializer_status
  );
`endif
endinterface

// File: rtl/serdesphy_ana_rx_deser.sv
// Behavioural RX deserializer: 2-flop line capture, K28.5 comma alignment, lock tracking.
// Define SERDESPHY_RX_PRBS_CHK_EN to add the self-seeding PRBS7 error counter.
//
// state  | meaning
// OFF    | disabled or soft reset, counters cleared
// SETTLE | waiting SETTLE_CYCLES after enable
// HUNT   | searching for a comma in any bit position
// ALIGN  | comma found, counting aligned commas towards lock
// LOCKED | word-aligned, emitting words, counting line errors
module serdesphy_ana_rx_deser #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_COMMAS   = 4,
  parameter int LOSS_ERRS     = 3,
  parameter int CNT_W         = 8
) (
  input logic                      clk_240m_rx,
  input logic                      rst,
  serdesphy_ana_rx_deser_if.slave  rx_if
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_HUNT   = 3'd2;
  localparam logic [2:0] ST_ALIGN  = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);
  localparam int ERRS_W = $clog2(LOSS_ERRS + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(LOCK_COMMAS);
  localparam logic [ERRS_W-1:0] ERRS_MAX    = ERRS_W'(LOSS_ERRS);
  localparam logic [9:0]        COMMA_P     = 10'b0011111010;
  localparam logic [9:0]        COMMA_N     = 10'b1100000101;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic [3:0]        r_phase;
  logic [GOOD_W-1:0] r_good;
  logic [ERRS_W-1:0] r_errs;
  logic [9:0]        r_shreg;
  logic [9:0]        r_word;
  logic              r_word_valid;
  logic              r_err_pulse;
  logic              r_p1;
  logic              r_p2;
  logic              r_n1;
  logic              r_n2;

  logic              w_sel_p;
  logic              w_sel_n;
  logic              w_invalid;
  logic              w_comma;
  logic              w_ph9;
  logic              w_line_err;
  logic              w_force_off;
  logic [3:0]        w_phase_nxt;
  logic [GOOD_W-1:0] w_good_inc;
  logic [ERRS_W-1:0] w_errs_inc;

  assign w_sel_p = rx_if.lpbk_en ? rx_if.lpbk_txp : rx_if.rxp;
  assign w_sel_n = rx_if.lpbk_en ? rx_if.lpbk_txn : rx_if.rxn;

  always_ff @(posedge clk_240m_rx or posedge rst) begin
    if (rst) begin
      r_p1 <= 1'b0;
      r_p2 <= 1'b0;
      r_n1 <= 1'b0;
      r_n2 <= 1'b0;
    end else begin
      r_p1 <= w_sel_p;
      r_p2 <= r_p1;
      r_n1 <= w_sel_n;
      r_n2 <= r_n1;
    end
  end

  always_ff @(posedge clk_240m_rx or posedge rst) begin
    if (rst) begin
      r_shreg <= 10'd0;
    end else if (r_state != ST_OFF) begin
      r_shreg <= {r_shreg[8:0], r_p2};
    end
  end

  // Comma is judged on the shifted history; validity on the bit arriving now.
  assign w_invalid   = (r_p2 == r_n2);
  assign w_comma     = (r_shreg == COMMA_P) || (r_shreg == COMMA_N);
  assign w_ph9       = (r_phase == 4'd9);
  assign w_line_err  = w_invalid || (w_comma && !w_ph9);
  assign w_force_off = !rx_if.deserializer_enable || !rx_if.deserializer_reset_n;
  assign w_phase_nxt = w_ph9 ? 4'd0 : r_phase + 4'd1;
  assign w_good_inc  = (r_good == GOOD_MAX) ? r_good : r_good + 1'b1;
  assign w_errs_inc  = (r_errs == ERRS_MAX) ? r_errs : r_errs + 1'b1;

  always_ff @(posedge clk_240m_rx or posedge rst) begin
    if (rst) begin
      r_state      <= ST_OFF;
      r_settle_cnt <= '0;
      r_phase      <= 4'd0;
      r_good       <= '0;
      r_errs       <= '0;
      r_word       <= 10'd0;
      r_word_valid <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_err_pulse  <= 1'b0;
      if (w_force_off) begin
        r_state      <= ST_OFF;
        r_settle_cnt <= '0;
        r_phase      <= 4'd0;
        r_good       <= '0;
        r_errs       <= '0;
      end else begin
        case (r_state)
          ST_OFF: begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state <= ST_HUNT;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          ST_HUNT: begin
            if (w_comma) begin
              r_state <= ST_ALIGN;
              r_phase <= 4'd0;
              r_good  <= GOOD_W'(1);
            end
          end
          ST_ALIGN: begin
            if (w_line_err) begin
              r_state <= ST_HUNT;
              r_phase <= 4'd0;
              r_good  <= '0;
            end else begin
              r_phase <= w_phase_nxt;
              if (w_ph9 && w_comma) begin
                r_good <= w_good_inc;
                if (w_good_inc == GOOD_MAX) begin
                  r_state <= ST_LOCKED;
                  r_errs  <= '0;
                end
              end
            end
          end
          ST_LOCKED: begin
            r_phase <= w_phase_nxt;
            if (w_ph9) begin
              r_word_valid <= 1'b1;
              r_word       <= r_shreg;
            end
            // An invalid bit outranks a simultaneous aligned comma.
            if (w_line_err) begin
              r_errs <= w_errs_inc;
              if (w_errs_inc == ERRS_MAX) begin
                r_state     <= ST_HUNT;
                r_err_pulse <= 1'b1;
                r_phase     <= 4'd0;
                r_good      <= '0;
              end
            end else if (w_comma) begin
              r_errs <= '0;
            end
          end
          default: begin
            r_state <= ST_OFF;
          end
        endcase
      end
    end
  end

  assign rx_if.deserializer_data   = rx_if.deserializer_bypass ? rx_if.rxp : r_p2;
  assign rx_if.word_out            = r_word;
  assign rx_if.word_valid          = r_word_valid && !rx_if.deserializer_bypass;
  assign rx_if.deserializer_ready  = (r_state == ST_HUNT) || (r_state == ST_ALIGN) ||
                                     (r_state == ST_LOCKED);
  assign rx_if.deserializer_lock   = (r_state == ST_LOCKED);
  assign rx_if.deserializer_error  = r_err_pulse;
  assign rx_if.deserializer_active = (r_state != ST_OFF);
  assign rx_if.deserializer_status = (r_state == ST_LOCKED) && (r_errs == '0);

`ifdef SERDESPHY_RX_PRBS_CHK_EN
  logic [6:0]  r_prbs_lfsr;
  logic [2:0]  r_prbs_fill;
  logic [15:0] r_prbs_errs;
  logic        w_prbs_exp;

  // Self-synchronising checker: received bits feed the LFSR, so each flip
  // is seen once directly and once at each of the two taps.
  assign w_prbs_exp = r_prbs_lfsr[6] ^ r_prbs_lfsr[5];

  always_ff @(posedge clk_240m_rx or posedge rst) begin
    if (rst) begin
      r_prbs_lfsr <= 7'd0;
      r_prbs_fill <= 3'd0;
      r_prbs_errs <= 16'd0;
    end else if (rx_if.prbs_clr) begin
      r_prbs_lfsr <= 7'd0;
      r_prbs_fill <= 3'd0;
      r_prbs_errs <= 16'd0;
    end else if ((r_state == ST_LOCKED) && rx_if.prbs_chk_en) begin
      r_prbs_lfsr <= {r_prbs_lfsr[5:0], r_p2};
      if (r_prbs_fill != 3'd7) begin
        r_prbs_fill <= r_prbs_fill + 3'd1;
      end else if ((r_p2 != w_prbs_exp) && (r_prbs_errs != 16'hFFFF)) begin
        r_prbs_errs <= r_prbs_errs + 16'd1;
      end
    end
  end

  assign rx_if.prbs_err_cnt = r_prbs_errs;
`endif

endmodule

// File: doc/serdesphy_ana_rx_deser.md
Name: serdesphy_ana_rx_deser

Overview:
- Behavioural mock of the analog RX deserializer that feeds the PMA deserializer status/data outputs.
- Samples the differential serial input (rxp/rxn, or the local TX pair in loopback) at 240 MHz and checks that the pair is valid.
- Aligns to K28.5 commas and emits 10-bit words plus the lock/ready/error/active/status flags the PMA exports.
- It is the receiving end of the TX serializer/driver path.

Parameters:
- SETTLE_CYCLES, 16, cycles spent in SETTLE after enable before hunting.
- LOCK_COMMAS, 4, consecutive aligned commas needed to declare lock.
- LOSS_ERRS, 3, consecutive line errors in LOCKED before dropping lock.
- CNT_W, 8, width of the settle counter (must hold SETTLE_CYCLES).

Ports:
- clk_240m_rx  in  1  240 MHz RX clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- deserializer_enable  in  1  block enable.
- deserializer_reset_n  in  1  synchronous soft reset (active-low); forces OFF.
- deserializer_bypass  in  1  test mode; raw rxp to deserializer_data.
- lpbk_en  in  1  selects lpbk_txp/lpbk_txn instead of rxp/rxn.
- rxp, rxn  in  1 each  differential line input.
- lpbk_txp, lpbk_txn  in  1 each  local TX pair for loopback.
- deserializer_data  out  1  recovered serial bit.
- word_out  out  10  aligned word, bit 9 first received.
- word_valid  out  1  one-cycle strobe, word_out valid.
- deserializer_ready  out  1  high in HUNT, ALIGN, LOCKED.
- deserializer_lock  out  1  high in LOCKED.
- deserializer_error  out  1  one-cycle pulse on loss of lock.
- deserializer_active  out  1  high in any state except OFF.
- deserializer_status  out  1  LOCKED and error count is 0.

Behaviour:
- Interface is fixed: one clock, clk_240m_rx; reset rst is asynchronous and active-high.
- Reset: every flop and output is 0; FSM is in OFF.
- Capture:
  - p/n are selected by lpbk_en, then pass through a 2-flop capture stage.
  - deserializer_data = captured p, so latency from line to output is 2 cycles.
  - Invalid bit: captured p == captured n.
- Bypass: when deserializer_bypass=1, deserializer_data = rxp combinationally and word_valid is forced 0. The FSM is unaffected.
- Shift register: 10 bits, shifts in captured p every cycle in every state except OFF.
- Comma: shreg equals 10'b0011111010 or 10'b1100000101.
- FSM, priority 1: enable=0 or deserializer_reset_n=0 forces OFF and clears all counters. This overrides everything else.
- OFF -> SETTLE when enabled. SETTLE counts to SETTLE_CYCLES-1, then -> HUNT.
- HUNT:
  - Comma -> ALIGN; phase counter = 0; good count = 1.
  - Invalid bits are ignored.
- ALIGN:
  - Phase counts 0..9 and wraps 9 -> 0.
  - At phase 9: comma increments the good count; a non-comma leaves the count unchanged.
  - Comma at phase != 9, or any invalid bit -> HUNT.
  - Good count reaching LOCK_COMMAS -> LOCKED.
- LOCKED:
  - At phase 9: word_valid=1 and word_out=shreg.
  - Line error = comma at phase != 9, or an invalid bit; each one increments the error count.
  - Aligned comma clears the error count. If an aligned comma and an invalid bit occur in the same cycle, the invalid bit wins (increment).
  - Error count reaching LOSS_ERRS -> HUNT with deserializer_error pulsed that cycle.
- Counters saturate; there is no wrap past their limits.

Optional Feature:
- Macro: SERDESPHY_RX_PRBS_CHK_EN.
- Defined:
  - Adds inputs prbs_chk_en (1) and prbs_clr (1), and output prbs_err_cnt (16).
  - While LOCKED and prbs_chk_en=1, the captured bit is compared to PRBS7 (x^7+x^6+1).
  - The 7-bit LFSR self-seeds from the first 7 received bits.
  - Each mismatch increments prbs_err_cnt, saturating at 16'hFFFF.
  - prbs_clr zeroes both counter and seed.
- Undefined: none of these ports or logic exist.

Test Plan:
- rst=1, then release with enable=0 -> all outputs 0, FSM OFF.
- Enable, SETTLE_CYCLES=16, drive repeated K28.5 followed by data words -> ready rises 16 cycles after enable; lock rises at the 4th aligned comma; word_valid strobes every 10 cycles with word_out=10'b0011111010 on commas.
- While LOCKED, force rxp=rxn for 3 bits -> error pulses one cycle, lock drops, FSM back in HUNT; resend commas -> relock after 4.
- lpbk_en=1, rxp/rxn idle, commas on lpbk_txp/lpbk_txn -> lock achieved; deserializer_data follows lpbk_txp with 2-cycle latency.
- Drop deserializer_reset_n mid-LOCKED -> next cycle active=0, lock=0, counters cleared; bypass=1 -> deserializer_data equals rxp the same cycle.
- With SERDESPHY_RX_PRBS_CHK_EN: feed PRBS7 with 5 injected bit flips -> prbs_err_cnt=15 (each flip costs 3 mismatches through the LFSR taps); prbs_clr -> 0.
